// File: rtl/uart_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_checker
//  Description : UART RX frame checker. Assembles a DATA_WIDTH-bit word from
//                sampled bits (LSB first), checks parity (even/odd/mark/space)
//                and the stop bit, emits one-cycle result pulses and keeps
//                saturating error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic                  busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    localparam logic [1:0] c_mode_even  = 2'd0;
    localparam logic [1:0] c_mode_odd   = 2'd1;
    localparam logic [1:0] c_mode_mark  = 2'd2;
    localparam logic [1:0] c_mode_space = 2'd3;

    // Four bits cover the largest legal word (9 bits).
    localparam logic [3:0] c_last_bit = 4'(DATA_WIDTH - 1);

    logic [1:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [3:0]            bit_cnt_q,  bit_cnt_d;
    logic                  par_acc_q,  par_acc_d;
    logic                  par_mis_q,  par_mis_d;
    logic                  par_en_q,   par_en_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
    logic                  dv_q,       dv_d;
    logic                  pe_q,       pe_d;
    logic                  se_q,       se_d;
    logic [CNT_WIDTH-1:0]  pcnt_q,     pcnt_d;
    logic [CNT_WIDTH-1:0]  scnt_q,     scnt_d;
    logic                  busy_d;
    logic                  w_exp_par;
    logic                  w_done;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame_start only matters in IDLE, bit_valid only outside it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:   if (frame_start) state_d = c_st_data;
            c_st_data:   if (bit_valid && (bit_cnt_q == c_last_bit))
                             state_d = par_en_q ? c_st_parity : c_st_stop;
            c_st_parity: if (bit_valid) state_d = c_st_stop;
            c_st_stop:   if (bit_valid) state_d = c_st_idle;
            default:     state_d = c_st_idle;
        endcase
    end

    // Expected parity bit for the mode latched at frame start.
    always_comb begin
        w_exp_par = par_acc_q;
        case (par_mode_q)
            c_mode_even:  w_exp_par = par_acc_q;
            c_mode_odd:   w_exp_par = ~par_acc_q;
            c_mode_mark:  w_exp_par = 1'b1;
            c_mode_space: w_exp_par = 1'b0;
            default:      w_exp_par = par_acc_q;
        endcase
    end

    // Frame datapath: latch config, shift bits in at the MSB, accumulate parity.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_acc_d  = par_acc_q;
        par_mis_d  = par_mis_q;
        par_en_d   = par_en_q;
        par_mode_d = par_mode_q;
        case (state_q)
            c_st_idle: begin
                if (frame_start) begin
                    par_en_d   = PAR_EN;
                    par_mode_d = PAR_MODE;
                    bit_cnt_d  = 4'd0;
                    par_acc_d  = 1'b0;
                    par_mis_d  = 1'b0;
                end
            end
            c_st_data: begin
                if (bit_valid) begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sampled_bit;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            c_st_parity: begin
                if (bit_valid) begin
                    par_mis_d = (sampled_bit != w_exp_par);
                end
            end
            default: ;
        endcase
    end

    // Outputs: result pulses one cycle after the stop bit, saturating counters,
    // and busy whenever a frame is in progress.
    always_comb begin
        w_done   = (state_q == c_st_stop) && bit_valid;
        p_data_d = w_done ? shift_q : p_data_q;
        pe_d     = w_done && par_mis_q;
        se_d     = w_done && !sampled_bit;
        dv_d     = w_done && !par_mis_q && sampled_bit;
        busy_d   = (state_q != c_st_idle);

        pcnt_d = pcnt_q;
        if (clr_cnt) begin
            pcnt_d = '0;
        end else if (pe_d && (pcnt_q != {CNT_WIDTH{1'b1}})) begin
            pcnt_d = pcnt_q + CNT_WIDTH'(1);
        end

        scnt_d = scnt_q;
        if (clr_cnt) begin
            scnt_d = '0;
        end else if (se_d && (scnt_q != {CNT_WIDTH{1'b1}})) begin
            scnt_d = scnt_q + CNT_WIDTH'(1);
        end
    end

    // Datapath and result registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q    <= '0;
            bit_cnt_q  <= 4'd0;
            par_acc_q  <= 1'b0;
            par_mis_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_mode_q <= 2'd0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            pcnt_q     <= '0;
            scnt_q     <= '0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_acc_q  <= par_acc_d;
            par_mis_q  <= par_mis_d;
            par_en_q   <= par_en_d;
            par_mode_q <= par_mode_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            pcnt_q     <= pcnt_d;
            scnt_q     <= scnt_d;
        end
    end

    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;
    assign par_err_cnt = pcnt_q;
    assign stp_err_cnt = scnt_q;
    assign busy        = busy_d;

endmodule
`default_nettype wire
